serv_dbus_ctrl: RTL and testbench
=================================

Name: serv_dbus_ctrl

Overview:
Data-bus master that sits directly downstream of the core state controller. It consumes the controller's level request o_dbus_cyc (wired to i_dbus_cyc here) and runs one Wishbone-classic access. It returns a one-cycle o_dbus_ack, which the controller uses to raise its RF write request. Address and store data arrive bit-serially, LSB first. Load data leaves bit-serially, byte-aligned and sign/zero-extended.

Parameters:
TIMEOUT, 0, cycles to wait for ack/err before forcing a bus error; 0 disables the timeout.

Ports:
i_clk  in  1  clock
i_rst  in  1  reset; asynchronous, active-high
i_cnt_en  in  1  serial cycle valid
i_cnt  in  5  current serial bit index 0..31
i_addr_en  in  1  shift i_addr_bit into address register
i_addr_bit  in  1  serial address bit, LSB first
i_data_en  in  1  shift i_data_bit into store register
i_data_bit  in  1  serial store data bit, LSB first
i_rd_en  in  1  shift load data out
i_dbus_cyc  in  1  access request level from state controller
i_we  in  1  1 = store
i_size  in  2  00 byte, 01 half, 10 word (11 treated as word)
i_signed  in  1  sign-extend loads
o_dbus_ack  out  1  one-cycle completion pulse to state controller
o_bus_err  out  1  qualifies o_dbus_ack; access faulted
o_rd_bit  out  1  serial load data bit
o_wb_adr  out  32  word address, bits [1:0] = 0
o_wb_dat  out  32  store data, lane-replicated
o_wb_sel  out  4  byte enables
o_wb_we  out  1  write enable
o_wb_cyc  out  1  cycle/strobe
i_wb_rdt  in  32  read data
i_wb_ack  in  1  slave ack
i_wb_err  in  1  slave error

Behaviour:
- Reset (async): state IDLE. Zero: o_wb_cyc, o_dbus_ack, o_bus_err, timeout counter, address/store/load registers, sign bit.
- Shifting:
  - When i_cnt_en & i_addr_en, and state is not WAIT: adr <= {i_addr_bit, adr[31:1]}. Same rule for the store register with i_data_en.
  - In WAIT both registers are frozen.
- Lane logic:
  - o_wb_adr = {adr[31:2], 2'b00}.
  - byte: sel = 0001 << adr[1:0]; dat = {4{st[7:0]}}.
  - half: sel = 0011 << {adr[1], 0}; dat = {2{st[15:0]}}.
  - word: sel = 1111; dat = st.
  - o_wb_we = i_we, sampled at issue and held in a register for the whole cycle.
- FSM IDLE -> WAIT -> HOLD -> IDLE:
  - IDLE: if i_dbus_cyc, then o_wb_cyc <= 1 and go to WAIT. o_wb_cyc rises on the edge that sampled i_dbus_cyc high (1 cycle latency).
  - WAIT, completion: on i_wb_err, i_wb_ack, or timeout: o_wb_cyc <= 0, o_dbus_ack <= 1 for exactly one cycle, go to HOLD.
    - o_bus_err <= i_wb_err | timeout.
    - err and ack in the same cycle: err wins and load data is not latched.
  - WAIT, ack only (i_wb_ack & !err): latch rd <= i_wb_rdt >> (8*adr[1:0]).
    - sign <= i_signed & (byte ? aligned[7] : aligned[15]); sign is 0 for word.
  - WAIT, request withdrawn: if i_dbus_cyc drops, the cycle still runs to completion; Wishbone accesses are never aborted.
  - Timeout: counter increments each WAIT cycle. With TIMEOUT = N > 0, the Nth WAIT cycle without ack/err completes as an error. The counter clears on entering WAIT.
  - HOLD: no new issue while i_dbus_cyc is high; the state controller keeps requesting until it leaves IDLE. When i_dbus_cyc = 0, go to IDLE.
- Read-out:
  - o_rd_bit = rd[0] when (word | (half & i_cnt < 16) | (byte & i_cnt < 8)); otherwise o_rd_bit = sign.
  - When i_cnt_en & i_rd_en: rd <= rd >> 1.
- o_bus_err holds its value until the next completion. o_dbus_ack is never high in two consecutive cycles.

Decomposition:
- Shared package holds:
  - size encodings SIZE_B/SIZE_H/SIZE_W;
  - FSM encoding IDLE/WAIT/HOLD (2 bits).
- Natural sub-module: serv_dbus_lane, combinational.
  - Inputs: adr[1:0], size, store register, i_wb_rdt.
  - Outputs: sel, replicated data, aligned read word and sign bit.
- The FSM and timeout counter stay in the top module.

Test Plan:
- Word store: shift adr = 0x0000_1004 and st = 0xDEADBEEF, raise i_dbus_cyc, ack after 3 cycles. Required: adr 0x1004, sel 1111, dat 0xDEADBEEF, we 1; o_dbus_ack is a single pulse; no second cyc while i_dbus_cyc is held high.
- Signed byte load: adr 0x2003, i_wb_rdt = 0x80FF_FF12, size byte, signed. Required: sel 1000; 32 serial o_rd_bit values = 0xFFFFFF80.
- Unsigned half load: adr 0x2002, i_wb_rdt = 0xA5A5_0000, unsigned. Required: sel 1100; serial output 0x0000A5A5.
- Error: i_wb_ack and i_wb_err both high in one cycle. Required: o_dbus_ack = 1 with o_bus_err = 1; rd register unchanged.
- Timeout: TIMEOUT = 4, slave silent. Required: o_wb_cyc drops and o_dbus_ack/o_bus_err pulse on the 4th WAIT cycle.
- Reset mid-WAIT: assert i_rst asynchronously. Required: o_wb_cyc falls without waiting for a clock edge; after release, the block is in IDLE and reissues if i_dbus_cyc is high.

Source files
------------

// File: rtl/serv_dbus_ctrl_pkg.sv
// Shared encodings for the serial data-bus master: access sizes and FSM states.
package serv_dbus_ctrl_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    HOLD = 2'b10
  } state_e;

endpackage

// File: rtl/serv_dbus_ctrl_if.sv
// Wishbone-classic data bus between the serial master and its slave.
interface serv_dbus_ctrl_if;
  logic [31:0] o_wb_adr;
  logic [31:0] o_wb_dat;
  logic [3:0]  o_wb_sel;
  logic        o_wb_we;
  logic        o_wb_cyc;
  logic [31:0] i_wb_rdt;
  logic        i_wb_ack;
  logic        i_wb_err;

  modport master (
    output o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc,
    input  i_wb_rdt, i_wb_ack, i_wb_err
  );

  modport slave (
    input  o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc,
    output i_wb_rdt, i_wb_ack, i_wb_err
  );
endinterface

// File: rtl/serv_dbus_lane.sv
// Byte-lane steering: store enables/replication and load alignment with sign pick.
module serv_dbus_lane
  import serv_dbus_ctrl_pkg::*;
(
  input  logic [1:0]  i_adr_lo,
  input  logic [1:0]  i_size,
  input  logic [31:0] i_st,
  input  logic [31:0] i_rdt,
  output logic [3:0]  o_sel,
  output logic [31:0] o_dat,
  output logic [31:0] o_aligned,
  output logic        o_sign
);

  always_comb begin
    o_sel     = 4'b1111;
    o_dat     = i_st;
    o_aligned = i_rdt >> {i_adr_lo, 3'b000};
    o_sign    = 1'b0;
    case (i_size)
      SIZE_B: begin
        o_sel  = 4'b0001 << i_adr_lo;
        o_dat  = {4{i_st[7:0]}};
        o_sign = o_aligned[7];
      end
      SIZE_H: begin
        o_sel  = 4'b0011 << {i_adr_lo[1], 1'b0};
        o_dat  = {2{i_st[15:0]}};
        o_sign = o_aligned[15];
      end
      default: ;  // word, and 11 treated as word
    endcase
  end

endmodule

// File: rtl/serv_dbus_ctrl.sv
// Serial-in/serial-out data-bus master running one Wishbone-classic access per request.
module serv_dbus_ctrl
  import serv_dbus_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cnt_en,
  input  logic [4:0]  i_cnt,
  input  logic        i_addr_en,
  input  logic        i_addr_bit,
  input  logic        i_data_en,
  input  logic        i_data_bit,
  input  logic        i_rd_en,
  input  logic        i_dbus_cyc,
  input  logic        i_we,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  output logic        o_dbus_ack,
  output logic        o_bus_err,
  output logic        o_rd_bit,
  serv_dbus_ctrl_if.master wb
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e        state, state_nxt;
  logic [TW-1:0] to_cnt;
  logic          to_hit, issue, done;
  logic [31:0]   adr, st, rd;
  logic          sign, we_r, cyc_r;
  logic [3:0]    lane_sel;
  logic [31:0]   lane_dat, lane_aligned;
  logic          lane_sign;

  serv_dbus_lane u_lane (
    .i_adr_lo  (adr[1:0]),
    .i_size    (i_size),
    .i_st      (st),
    .i_rdt     (wb.i_wb_rdt),
    .o_sel     (lane_sel),
    .o_dat     (lane_dat),
    .o_aligned (lane_aligned),
    .o_sign    (lane_sign)
  );

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    done      = 1'b0;
    to_hit    = (TIMEOUT > 0) && (to_cnt == TW'(TIMEOUT - 1));
    case (state)
      IDLE: if (i_dbus_cyc) begin
        issue     = 1'b1;
        state_nxt = WAIT;
      end
      // Withdrawing i_dbus_cyc here does not abort; the slave must finish.
      WAIT: if (wb.i_wb_err | wb.i_wb_ack | to_hit) begin
        done      = 1'b1;
        state_nxt = HOLD;
      end
      HOLD: if (!i_dbus_cyc) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      cyc_r      <= 1'b0;
      we_r       <= 1'b0;
      o_dbus_ack <= 1'b0;
      o_bus_err  <= 1'b0;
      to_cnt     <= '0;
      adr        <= '0;
      st         <= '0;
      rd         <= '0;
      sign       <= 1'b0;
    end else begin
      state      <= state_nxt;
      o_dbus_ack <= done;
      if (state == WAIT) to_cnt <= to_cnt + 1'b1;
      if (issue) begin
        cyc_r  <= 1'b1;
        we_r   <= i_we;
        to_cnt <= '0;
      end
      if (done) begin
        cyc_r     <= 1'b0;
        o_bus_err <= wb.i_wb_err | to_hit;
      end
      if (state != WAIT && i_cnt_en && i_addr_en) adr <= {i_addr_bit, adr[31:1]};
      if (state != WAIT && i_cnt_en && i_data_en) st  <= {i_data_bit, st[31:1]};
      // An error in the same cycle as ack leaves the previous load data intact.
      if (done && wb.i_wb_ack && !wb.i_wb_err) begin
        rd   <= lane_aligned;
        sign <= i_signed & lane_sign;
      end else if (i_cnt_en && i_rd_en) begin
        rd <= {1'b0, rd[31:1]};
      end
    end
  end

  always_comb begin
    case (i_size)
      SIZE_B:  o_rd_bit = (i_cnt < 5'd8)  ? rd[0] : sign;
      SIZE_H:  o_rd_bit = (i_cnt < 5'd16) ? rd[0] : sign;
      default: o_rd_bit = rd[0];
    endcase
  end

  assign wb.o_wb_adr = {adr[31:2], 2'b00};
  assign wb.o_wb_dat = lane_dat;
  assign wb.o_wb_sel = lane_sel;
  assign wb.o_wb_we  = we_r;
  assign wb.o_wb_cyc = cyc_r;

endmodule

// File: tb/tb_serv_dbus_ctrl.sv
// Directed bench for serv_dbus_ctrl with TIMEOUT = 4.
module tb_serv_dbus_ctrl;
  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_cnt_en = 0, i_addr_en = 0, i_addr_bit = 0, i_data_en = 0, i_data_bit = 0;
  logic       i_rd_en = 0, i_dbus_cyc = 0, i_we = 0, i_signed = 0;
  logic [4:0] i_cnt = '0;
  logic [1:0] i_size = 2'b10;
  logic       o_dbus_ack, o_bus_err, o_rd_bit;
  int n_chk = 0, n_fail = 0;

  serv_dbus_ctrl_if wb();

  serv_dbus_ctrl #(.TIMEOUT(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_cnt_en(i_cnt_en), .i_cnt(i_cnt),
    .i_addr_en(i_addr_en), .i_addr_bit(i_addr_bit), .i_data_en(i_data_en),
    .i_data_bit(i_data_bit), .i_rd_en(i_rd_en), .i_dbus_cyc(i_dbus_cyc),
    .i_we(i_we), .i_size(i_size), .i_signed(i_signed), .o_dbus_ack(o_dbus_ack),
    .o_bus_err(o_bus_err), .o_rd_bit(o_rd_bit), .wb(wb)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic shift_in(input logic [31:0] a, input logic [31:0] s);
    for (int i = 0; i < 32; i++) begin
      i_cnt = 5'(i); i_cnt_en = 1; i_addr_en = 1; i_data_en = 1;
      i_addr_bit = a[i]; i_data_bit = s[i];
      tick();
    end
    i_cnt_en = 0; i_addr_en = 0; i_data_en = 0; i_cnt = '0;
  endtask

  task automatic read_out(output logic [31:0] v);
    v = '0;
    for (int i = 0; i < 32; i++) begin
      i_cnt = 5'(i); i_cnt_en = 1; i_rd_en = 1;
      #1;
      v[i] = o_rd_bit;
      tick();
    end
    i_cnt_en = 0; i_rd_en = 0; i_cnt = '0;
  endtask

  task automatic test_reset;
    n_chk++; if (wb.o_wb_cyc !== 1'b0) begin n_fail++; $display("FAIL reset_cyc got %b exp 0", wb.o_wb_cyc); end
    n_chk++; if (o_dbus_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack got %b exp 0", o_dbus_ack); end
    n_chk++; if (o_bus_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", o_bus_err); end
    n_chk++; if (o_rd_bit !== 1'b0) begin n_fail++; $display("FAIL reset_rd_bit got %b exp 0", o_rd_bit); end
    n_chk++; if (wb.o_wb_adr !== 32'h0) begin n_fail++; $display("FAIL reset_adr got %h exp 0", wb.o_wb_adr); end
    @(negedge i_clk); i_rst = 0;
    tick();
  endtask

  task automatic test_word_store;
    int pulses, cycs;
    shift_in(32'h0000_1004, 32'hDEAD_BEEF);
    i_size = 2'b10; i_we = 1; i_dbus_cyc = 1;
    tick();
    n_chk++; if (wb.o_wb_cyc !== 1'b1) begin n_fail++; $display("FAIL ws_cyc got %b exp 1", wb.o_wb_cyc); end
    n_chk++; if (wb.o_wb_adr !== 32'h0000_1004) begin n_fail++; $display("FAIL ws_adr got %h exp 00001004", wb.o_wb_adr); end
    n_chk++; if (wb.o_wb_sel !== 4'b1111) begin n_fail++; $display("FAIL ws_sel got %b exp 1111", wb.o_wb_sel); end
    n_chk++; if (wb.o_wb_dat !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ws_dat got %h exp deadbeef", wb.o_wb_dat); end
    n_chk++; if (wb.o_wb_we !== 1'b1) begin n_fail++; $display("FAIL ws_we got %b exp 1", wb.o_wb_we); end
    i_we = 0;
    tick(); tick();
    n_chk++; if (wb.o_wb_cyc !== 1'b1 || wb.o_wb_we !== 1'b1 || o_dbus_ack !== 1'b0)
      begin n_fail++; $display("FAIL ws_wait cyc/we/ack got %b%b%b exp 110", wb.o_wb_cyc, wb.o_wb_we, o_dbus_ack); end
    wb.i_wb_ack = 1;
    tick();
    wb.i_wb_ack = 0;
    n_chk++; if (o_dbus_ack !== 1'b1 || o_bus_err !== 1'b0 || wb.o_wb_cyc !== 1'b0)
      begin n_fail++; $display("FAIL ws_done ack/err/cyc got %b%b%b exp 100", o_dbus_ack, o_bus_err, wb.o_wb_cyc); end
    pulses = 0; cycs = 0;
    repeat (5) begin tick(); pulses += int'(o_dbus_ack); cycs += int'(wb.o_wb_cyc); end
    n_chk++; if (pulses != 0 || cycs != 0)
      begin n_fail++; $display("FAIL ws_hold extra acks %0d cycs %0d exp 0 0", pulses, cycs); end
    i_dbus_cyc = 0;
    tick();
  endtask

  task automatic test_byte_load;
    logic [31:0] v;
    shift_in(32'h0000_2003, 32'h0);
    i_size = 2'b00; i_signed = 1; i_we = 0; wb.i_wb_rdt = 32'h80FF_FF12; i_dbus_cyc = 1;
    tick();
    n_chk++; if (wb.o_wb_sel !== 4'b1000 || wb.o_wb_we !== 1'b0)
      begin n_fail++; $display("FAIL bl_sel/we got %b/%b exp 1000/0", wb.o_wb_sel, wb.o_wb_we); end
    n_chk++; if (wb.o_wb_adr !== 32'h0000_2000) begin n_fail++; $display("FAIL bl_adr got %h exp 00002000", wb.o_wb_adr); end
    wb.i_wb_ack = 1;
    tick();
    wb.i_wb_ack = 0; i_dbus_cyc = 0;
    n_chk++; if (o_dbus_ack !== 1'b1) begin n_fail++; $display("FAIL bl_ack got %b exp 1", o_dbus_ack); end
    tick();
    read_out(v);
    n_chk++; if (v !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL bl_data got %h exp ffffff80", v); end
    i_signed = 0;
  endtask

  task automatic test_half_load;
    logic [31:0] v;
    shift_in(32'h0000_2002, 32'h0);
    i_size = 2'b01; i_signed = 0; wb.i_wb_rdt = 32'hA5A5_0000; i_dbus_cyc = 1;
    tick();
    n_chk++; if (wb.o_wb_sel !== 4'b1100) begin n_fail++; $display("FAIL hl_sel got %b exp 1100", wb.o_wb_sel); end
    tick();
    wb.i_wb_ack = 1;
    tick();
    wb.i_wb_ack = 0; i_dbus_cyc = 0;
    tick();
    read_out(v);
    n_chk++; if (v !== 32'h0000_A5A5) begin n_fail++; $display("FAIL hl_data got %h exp 0000a5a5", v); end
  endtask

  task automatic test_error;
    logic [31:0] v;
    shift_in(32'h0000_3000, 32'h0);
    i_size = 2'b10; wb.i_wb_rdt = 32'h1234_5678; i_dbus_cyc = 1;
    tick();
    wb.i_wb_ack = 1; tick(); wb.i_wb_ack = 0; i_dbus_cyc = 0;
    tick();
    wb.i_wb_rdt = 32'hCAFE_F00D; i_dbus_cyc = 1;
    tick();
    wb.i_wb_ack = 1; wb.i_wb_err = 1;
    tick();
    wb.i_wb_ack = 0; wb.i_wb_err = 0;
    n_chk++; if (o_dbus_ack !== 1'b1 || o_bus_err !== 1'b1)
      begin n_fail++; $display("FAIL er_done ack/err got %b%b exp 11", o_dbus_ack, o_bus_err); end
    i_dbus_cyc = 0;
    tick();
    n_chk++; if (o_dbus_ack !== 1'b0 || o_bus_err !== 1'b1)
      begin n_fail++; $display("FAIL er_hold ack/err got %b%b exp 01", o_dbus_ack, o_bus_err); end
    read_out(v);
    n_chk++; if (v !== 32'h1234_5678) begin n_fail++; $display("FAIL er_rd_kept got %h exp 12345678", v); end
  endtask

  task automatic test_timeout;
    int bad;
    i_dbus_cyc = 1;
    tick();
    bad = 0;
    repeat (3) begin
      tick();
      if (wb.o_wb_cyc !== 1'b1 || o_dbus_ack !== 1'b0) bad++;
    end
    n_chk++; if (bad != 0) begin n_fail++; $display("FAIL to_early got %0d early completions exp 0", bad); end
    tick();
    n_chk++; if (wb.o_wb_cyc !== 1'b0 || o_dbus_ack !== 1'b1 || o_bus_err !== 1'b1)
      begin n_fail++; $display("FAIL to_fire cyc/ack/err got %b%b%b exp 011", wb.o_wb_cyc, o_dbus_ack, o_bus_err); end
    i_dbus_cyc = 0;
    tick();
  endtask

  task automatic test_reset_mid_wait;
    i_dbus_cyc = 1;
    tick();
    n_chk++; if (wb.o_wb_cyc !== 1'b1) begin n_fail++; $display("FAIL rm_issue got %b exp 1", wb.o_wb_cyc); end
    #2 i_rst = 1;
    #1;
    n_chk++; if (wb.o_wb_cyc !== 1'b0 || o_bus_err !== 1'b0)
      begin n_fail++; $display("FAIL rm_async cyc/err got %b%b exp 00", wb.o_wb_cyc, o_bus_err); end
    #2 i_rst = 0;
    tick();
    n_chk++; if (wb.o_wb_cyc !== 1'b1 || o_dbus_ack !== 1'b0)
      begin n_fail++; $display("FAIL rm_reissue cyc/ack got %b%b exp 10", wb.o_wb_cyc, o_dbus_ack); end
    wb.i_wb_ack = 1; tick(); wb.i_wb_ack = 0; i_dbus_cyc = 0;
    n_chk++; if (o_dbus_ack !== 1'b1 || o_bus_err !== 1'b0)
      begin n_fail++; $display("FAIL rm_done ack/err got %b%b exp 10", o_dbus_ack, o_bus_err); end
    tick();
  endtask

  initial begin
    wb.i_wb_rdt = '0; wb.i_wb_ack = 0; wb.i_wb_err = 0;
    #12;
    test_reset();
    test_word_store();
    test_byte_load();
    test_half_load();
    test_error();
    test_timeout();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
